// File: rtl/mux_nway_arb_pkg.sv
// Shared definitions for the N-way arbitrated mux: mode encoding and a
// constant-function log2 for sizing select/channel-ID fields.
package mux_nway_arb_pkg;

  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } mode_e;

  // Smallest r with 2**r >= value; evaluated at elaboration time.
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_nway_arb_rr_arbiter.sv
// Combinational grant logic: fixed select or round-robin search starting at
// the pointer and wrapping, producing a one-hot grant plus its encoded index.
module mux_nway_arb_rr_arbiter
  import mux_nway_arb_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic [CHANNELS-1:0] valid_i,
  input  logic [SEL_W-1:0]    rr_ptr_i,
  input  logic                mode_i,
  input  logic [SEL_W-1:0]    sel_i,
  output logic [CHANNELS-1:0] grant_o,
  output logic [SEL_W-1:0]    idx_o,
  output logic                any_o
);

  logic             hi_hit;
  logic             lo_hit;
  logic             fix_hit;
  logic [SEL_W-1:0] hi_idx;
  logic [SEL_W-1:0] lo_idx;

  // Lowest valid channel at/above the pointer (hi) and lowest overall (lo, the wrap case).
  always_comb begin
    hi_hit  = 1'b0;
    lo_hit  = 1'b0;
    fix_hit = 1'b0;
    hi_idx  = '0;
    lo_idx  = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      lo_hit = lo_hit | valid_i[i];
      lo_idx = valid_i[i] ? SEL_W'(i) : lo_idx;
      hi_hit = hi_hit | (valid_i[i] && (i >= int'(rr_ptr_i)));
      hi_idx = (valid_i[i] && (i >= int'(rr_ptr_i))) ? SEL_W'(i) : hi_idx;
    end
    // A select value beyond the channel count matches nothing, so it grants nobody.
    for (int i = 0; i < CHANNELS; i++) begin
      fix_hit = fix_hit | ((sel_i == SEL_W'(i)) && valid_i[i]);
    end
  end

  // Final choice between fixed and round-robin, then one-hot expansion.
  always_comb begin
    any_o   = 1'b0;
    idx_o   = '0;
    grant_o = '0;
    if (mode_i == MODE_FIXED) begin
      any_o = fix_hit;
      idx_o = sel_i;
    end else if (hi_hit) begin
      any_o = 1'b1;
      idx_o = hi_idx;
    end else begin
      any_o = lo_hit;
      idx_o = lo_idx;
    end
    for (int i = 0; i < CHANNELS; i++) begin
      grant_o[i] = any_o && (idx_o == SEL_W'(i));
    end
  end

endmodule

// File: rtl/mux_nway_arb.sv
// N-channel, W-bit mux with valid/ready on every port, a single registered
// output stage and either fixed-select or round-robin channel choice.
module mux_nway_arb
  import mux_nway_arb_pkg::*;
#(
  parameter int  WIDTH    = 16,
  parameter int  CHANNELS = 4,
  localparam int SEL_W    = clog2_f(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    gnt_idx;
  logic                gnt_any;
  logic                can_load;
  logic                xfer;

  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_ch_q,   out_ch_d;
  logic                out_valid_q, out_valid_d;
  logic [SEL_W-1:0]    rr_ptr_q,   rr_ptr_d;

  mux_nway_arb_rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_arb (
    .valid_i  (in_valid),
    .rr_ptr_i (rr_ptr_q),
    .mode_i   (mode),
    .sel_i    (sel),
    .grant_o  (grant),
    .idx_o    (gnt_idx),
    .any_o    (gnt_any)
  );

  // Handshake: the stage can take a word when empty or being drained this cycle.
  always_comb begin
    can_load = !out_valid_q || out_ready;
    xfer     = gnt_any && can_load && rst_n;
    if (rst_n) begin
      in_ready = grant & {CHANNELS{can_load}};
    end else begin
      in_ready = '0;
    end
  end

  // Next state for the output register and the round-robin pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_data_d  = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
      out_ch_d    = gnt_idx;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (xfer && (mode == MODE_RR)) begin
      if (int'(gnt_idx) == CHANNELS - 1) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = gnt_idx + SEL_W'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // State registers; reset discards any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nway_arb.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase compared every cycle against a behavioural model.
module tb_mux_nway_arb;

  localparam int W  = 16;
  localparam int C  = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [C*W-1:0]  in_data;
  logic [C-1:0]    in_valid;
  logic [C-1:0]    in_ready;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_ch;
  logic            out_valid;
  logic            out_ready;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [W-1:0] pat [4] = '{16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000};

  // behavioural model state
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_ch;
  int           m_ptr;
  int           exp_g;
  logic         exp_can;
  logic [C-1:0] exp_rdy;

  mux_nway_arb #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Which channel the rules say wins, or -1 for none.
  function automatic int pick(logic [C-1:0] v, logic md, int s, int ptr);
    if (md == 1'b1) begin
      if (s < C) begin
        if (v[s]) return s;
      end
      return -1;
    end
    for (int k = 0; k < C; k++) begin
      if (v[(ptr + k) % C]) return (ptr + k) % C;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  always_comb begin
    exp_g   = pick(in_valid, mode, int'(sel), m_ptr);
    exp_can = !m_valid || out_ready;
    exp_rdy = '0;
    if (exp_g >= 0 && exp_can) exp_rdy[exp_g] = 1'b1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ch    <= 0;
      m_ptr   <= 0;
    end else if (exp_g >= 0 && exp_can) begin
      m_valid <= 1'b1;
      m_data  <= in_data[exp_g*W +: W];
      m_ch    <= exp_g;
      if (mode == 1'b0) m_ptr <= (exp_g + 1) % C;
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst_n) begin
        check("rst_rdy",   32'(in_ready),  32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data",  32'(out_data),  32'h0);
        check("rst_ch",    32'(out_ch),    32'h0);
      end else begin
        check("mdl_valid", 32'(out_valid), 32'(m_valid));
        check("mdl_data",  32'(out_data),  32'(m_data));
        check("mdl_ch",    32'(out_ch),    32'(m_ch));
        check("mdl_rdy",   32'(in_ready),  32'(exp_rdy));
      end
    end
  end

  task automatic expect_word(input string name, input int ch);
    check({name, "_valid"}, 32'(out_valid), 32'h1);
    check({name, "_ch"},    32'(out_ch),    32'(ch));
    check({name, "_data"},  32'(out_data),  32'(pat[ch]));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    mode      = 1'b0;
    sel       = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    #2;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      cyc();
      check("idle_valid", 32'(out_valid), 32'h0);
      check("idle_data",  32'(out_data),  32'h0);
      check("idle_rdy",   32'(in_ready),  32'h0);
    end

    in_data   = {16'h0000, 16'hFFFF, 16'h5555, 16'hAAAA};
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    mode      = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel = SW'(s);
      cyc();
      expect_word("fixed", s);
    end

    mode = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      expect_word("rr", k % 4);
    end

    cyc(); expect_word("rr_pre", 0);
    cyc(); expect_word("rr_pre", 1);
    in_valid = 4'b1010;
    cyc(); expect_word("sparse", 3);
    cyc(); expect_word("sparse", 1);
    cyc(); expect_word("sparse", 3);
    cyc(); expect_word("sparse", 1);
    cyc(); expect_word("sparse", 3);
    in_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      cyc();
      expect_word("drop3", 1);
    end
    in_valid = 4'b1000;
    cyc(); expect_word("wrap", 3);

    in_valid = 4'b1111;
    cyc(); expect_word("bp_first", 0);
    out_ready = 1'b0;
    #1;
    check("bp_rdy_now", 32'(in_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      expect_word("bp_hold", 0);
      check("bp_rdy", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    cyc(); expect_word("bp_next", 1);
    out_ready = 1'b0;
    cyc(); expect_word("bp_hold2", 1);

    #1;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_data",  32'(out_data),  32'h0);
    check("arst_rdy",   32'(in_ready),  32'h0);
    cyc();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    cyc(); expect_word("post_rst", 0);

    for (int n = 0; n < 3000; n++) begin
      in_valid  = C'($urandom);
      in_data   = {$urandom, $urandom};
      mode      = ($urandom_range(0, 3) == 0);
      sel       = SW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
